// File: rtl/csr_trap_ctrl_if.sv
// csr_trap_ctrl_if: retire-side flags, CSR strobes and fetch redirect of the trap sequencer.
// Latency: none, this is a bundle of wires.
// Backpressure: redirect_valid_o/redirect_ready_i is the only handshake carried here.
interface csr_trap_ctrl_if;
  logic        instr_valid_i;
  logic [31:0] pc_i;
  logic        illegal_i;
  logic        ecall_i;
  logic        ebreak_i;
  logic        mret_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic        redirect_ready_i;

  logic [1:0]  exception_o;
  logic        mepc_we_o;
  logic [31:0] mepc_wdata_o;
  logic        mie_save_o;
  logic        mret_restore_o;
  logic        stall_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;

  // Trap sequencer side.
  modport master (
    input  instr_valid_i, pc_i, illegal_i, ecall_i, ebreak_i, mret_i,
    input  mtvec_i, mepc_i, redirect_ready_i,
    output exception_o, mepc_we_o, mepc_wdata_o, mie_save_o, mret_restore_o,
    output stall_o, flush_o, redirect_valid_o, redirect_pc_o
  );

  // Pipeline / CSR file / fetch side.
  modport slave (
    output instr_valid_i, pc_i, illegal_i, ecall_i, ebreak_i, mret_i,
    output mtvec_i, mepc_i, redirect_ready_i,
    input  exception_o, mepc_we_o, mepc_wdata_o, mie_save_o, mret_restore_o,
    input  stall_o, flush_o, redirect_valid_o, redirect_pc_o
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: turns a retiring exception/mret into mcause/mepc/mstatus strobes plus a fetch redirect.
// Latency: event in IDLE cycle N -> CSR pulses in N+1 -> redirect_valid_o from N+2 until accepted.
// Backpressure: REDIRECT holds target and stall until redirect_ready_i; events outside IDLE are dropped.
module csr_trap_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  csr_trap_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRAP     = 2'd1,
    RET      = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cause;
  logic [31:0] r_epc;
  logic [31:0] r_target;

  logic        w_any_trap;
  logic        w_trap_evt;
  logic        w_mret_evt;
  logic [1:0]  w_code;
  logic        w_unused_low_bits;

  // mret only counts when no trap flag is present; a trap flag always wins.
  assign w_any_trap = bus.illegal_i | bus.ebreak_i | bus.ecall_i;
  assign w_trap_evt = bus.instr_valid_i & w_any_trap;
  assign w_mret_evt = bus.instr_valid_i & bus.mret_i & ~w_any_trap;

  // The MODE bits of mtvec and the low bits of mepc never reach the target.
  assign w_unused_low_bits = ^{bus.mtvec_i[1:0], bus.mepc_i[1:0]};

  // Cause encoding with priority illegal > ebreak > ecall; only used on a trap event.
  always_comb begin
    w_code = 2'b10;
    if (bus.illegal_i) begin
      w_code = 2'b01;
    end else if (bus.ebreak_i) begin
      w_code = 2'b11;
    end
  end

  // State register; reset drops any pending redirect.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture cause, faulting PC and redirect target at the moment an event is accepted.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cause  <= 2'b00;
      r_epc    <= PC_RESET;
      r_target <= PC_RESET;
    end else if (r_state == IDLE) begin
      if (w_trap_evt) begin
        r_cause  <= w_code;
        r_epc    <= bus.pc_i;
        r_target <= {bus.mtvec_i[31:2], 2'b00};
      end else if (w_mret_evt) begin
        r_target <= {bus.mepc_i[31:2], 2'b00};
      end
    end
  end

  // Next-state and per-state strobes; everything defaults to idle-quiet.
  always_comb begin
    w_state_nxt          = r_state;
    bus.exception_o      = 2'b00;
    bus.mepc_we_o        = 1'b0;
    bus.mie_save_o       = 1'b0;
    bus.mret_restore_o   = 1'b0;
    bus.stall_o          = 1'b0;
    bus.flush_o          = 1'b0;
    bus.redirect_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        // Stall combinationally in the detect cycle so the trapping instruction holds.
        bus.stall_o = w_trap_evt | w_mret_evt;
        if (w_trap_evt) begin
          w_state_nxt = TRAP;
        end else if (w_mret_evt) begin
          w_state_nxt = RET;
        end
      end
      TRAP: begin
        bus.exception_o = r_cause;
        bus.mepc_we_o   = 1'b1;
        bus.mie_save_o  = 1'b1;
        bus.flush_o     = 1'b1;
        bus.stall_o     = 1'b1;
        w_state_nxt     = REDIRECT;
      end
      RET: begin
        bus.mret_restore_o = 1'b1;
        bus.flush_o        = 1'b1;
        bus.stall_o        = 1'b1;
        w_state_nxt        = REDIRECT;
      end
      REDIRECT: begin
        bus.redirect_valid_o = 1'b1;
        bus.stall_o          = 1'b1;
        if (bus.redirect_ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Data outputs are straight views of the captured registers, stable through REDIRECT.
  assign bus.mepc_wdata_o  = r_epc;
  assign bus.redirect_pc_o = r_target;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl: table vectors, directed corner sequences and random stimulus against a cycle-age model.
// Latency: inputs driven on falling edge, outputs sampled 1ns later, model advanced at the rising edge.
// Backpressure: redirect_ready_i driven from tables, sequences or $urandom.
module tb_csr_trap_ctrl;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  csr_trap_ctrl_if bus();

  csr_trap_ctrl #(.PC_RESET(32'h0000_0000)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: "busy" means a sequence is in progress; m_age counts cycles since acceptance.
  bit          m_busy    = 1'b0;
  int          m_age     = 0;
  bit          m_is_trap = 1'b0;
  logic [1:0]  m_cause   = 2'b00;
  logic [31:0] m_epc     = 32'h0;
  logic [31:0] m_target  = 32'h0;

  typedef struct {
    logic        il, ec, eb, mr;
    logic [31:0] pc, mtvec, mepc;
    logic [1:0]  exp_exc;
    logic        exp_we, exp_save, exp_rest;
    logic [31:0] exp_target;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic il, input logic ec,
                       input logic eb, input logic mr, input logic [31:0] mtvec,
                       input logic [31:0] mepc, input logic rdy);
    bus.instr_valid_i    = v;
    bus.pc_i             = pc;
    bus.illegal_i        = il;
    bus.ecall_i          = ec;
    bus.ebreak_i         = eb;
    bus.mret_i           = mr;
    bus.mtvec_i          = mtvec;
    bus.mepc_i           = mepc;
    bus.redirect_ready_i = rdy;
  endtask

  task automatic drive_quiet(input logic rdy);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rdy);
  endtask

  function automatic logic [1:0] cause_of(input logic il, input logic ec, input logic eb);
    logic [1:0] code;
    code = 2'b00;
    if (ec) code = 2'b10;
    if (eb) code = 2'b11;
    if (il) code = 2'b01;
    return code;
  endfunction

  // Settle, then compare every output against what the model predicts for this cycle.
  task automatic sample(input string tag);
    logic       ev;
    logic [1:0] e_exc;
    logic       e_we, e_save, e_rest, e_stall, e_flush, e_rv;
    #1;
    ev = bus.instr_valid_i & (bus.illegal_i | bus.ecall_i | bus.ebreak_i | bus.mret_i);
    e_exc = 2'b00; e_we = 0; e_save = 0; e_rest = 0; e_stall = 0; e_flush = 0; e_rv = 0;
    if (!m_busy) begin
      e_stall = ev;
    end else if (m_age == 1) begin
      e_stall = 1; e_flush = 1;
      if (m_is_trap) begin
        e_exc = m_cause; e_we = 1; e_save = 1;
      end else begin
        e_rest = 1;
      end
    end else begin
      e_stall = 1; e_rv = 1;
    end
    chk({tag, ".outs"},
        {23'h0, bus.exception_o, bus.mepc_we_o, bus.mie_save_o, bus.mret_restore_o,
         bus.stall_o, bus.flush_o, bus.redirect_valid_o},
        {23'h0, e_exc, e_we, e_save, e_rest, e_stall, e_flush, e_rv});
    chk({tag, ".mepc_wdata"}, bus.mepc_wdata_o, m_epc);
    chk({tag, ".redirect_pc"}, bus.redirect_pc_o, m_target);
  endtask

  // Clock the DUT and step the model with the inputs present at the rising edge.
  task automatic advance();
    logic ev, tr;
    @(posedge clk_i);
    ev = bus.instr_valid_i & (bus.illegal_i | bus.ecall_i | bus.ebreak_i | bus.mret_i);
    tr = bus.instr_valid_i & (bus.illegal_i | bus.ecall_i | bus.ebreak_i);
    if (!rst_i) begin
      m_busy = 0; m_age = 0; m_cause = 2'b00; m_epc = 32'h0; m_target = 32'h0;
    end else if (!m_busy) begin
      if (ev) begin
        m_busy = 1; m_age = 1; m_is_trap = tr;
        if (tr) begin
          m_cause  = cause_of(bus.illegal_i, bus.ecall_i, bus.ebreak_i);
          m_epc    = bus.pc_i;
          m_target = bus.mtvec_i & 32'hFFFF_FFFC;
        end else begin
          m_target = bus.mepc_i & 32'hFFFF_FFFC;
        end
      end
    end else if (m_age >= 2 && bus.redirect_ready_i) begin
      m_busy = 0;
    end else begin
      m_age++;
    end
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h40,   32'h103,  32'h0,   2'b01, 1'b1, 1'b1, 1'b0, 32'h100};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h1000, 32'h2000, 32'h0,   2'b01, 1'b1, 1'b1, 1'b0, 32'h2000};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h1004, 32'h3002, 32'h0,   2'b11, 1'b1, 1'b1, 1'b0, 32'h3000};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h80,   32'h401,  32'h0,   2'b10, 1'b1, 1'b1, 1'b0, 32'h400};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h88,   32'h500,  32'h44,  2'b00, 1'b0, 1'b0, 1'b1, 32'h44};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h90,   32'h600,  32'h700, 2'b10, 1'b1, 1'b1, 1'b0, 32'h600};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h94,   32'h800,  32'h4B,  2'b00, 1'b0, 1'b0, 1'b1, 32'h48};

    // Reset state.
    rst_i = 1'b0;
    drive_quiet(1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    sample("reset");
    chk("reset.stall", {31'h0, bus.stall_o}, 32'h0);
    chk("reset.redirect_pc", bus.redirect_pc_o, 32'h0);
    rst_i = 1'b1;
    advance();

    // Table vectors: one full sequence each with ready already high.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vecs[i].pc, vecs[i].il, vecs[i].ec, vecs[i].eb, vecs[i].mr,
            vecs[i].mtvec, vecs[i].mepc, 1'b1);
      sample($sformatf("vec%0d.N", i));
      chk($sformatf("vec%0d.N.stall", i), {31'h0, bus.stall_o}, 32'h1);
      advance();
      drive_quiet(1'b1);
      sample($sformatf("vec%0d.N1", i));
      chk($sformatf("vec%0d.N1.pulses", i),
          {27'h0, bus.exception_o, bus.mepc_we_o, bus.mie_save_o, bus.mret_restore_o},
          {27'h0, vecs[i].exp_exc, vecs[i].exp_we, vecs[i].exp_save, vecs[i].exp_rest});
      chk($sformatf("vec%0d.N1.flush", i), {31'h0, bus.flush_o}, 32'h1);
      if (vecs[i].exp_we) chk($sformatf("vec%0d.N1.wdata", i), bus.mepc_wdata_o, vecs[i].pc);
      advance();
      sample($sformatf("vec%0d.N2", i));
      chk($sformatf("vec%0d.N2.valid", i), {31'h0, bus.redirect_valid_o}, 32'h1);
      chk($sformatf("vec%0d.N2.target", i), bus.redirect_pc_o, vecs[i].exp_target);
      advance();
      sample($sformatf("vec%0d.idle", i));
      chk($sformatf("vec%0d.idle.stall", i), {31'h0, bus.stall_o}, 32'h0);
      advance();
    end

    // Redirect backpressure with a flag pulsed during the wait.
    drive(1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 1'b0);
    sample("bp.N"); advance();
    drive_quiet(1'b0);
    sample("bp.N1");
    chk("bp.N1.exc", {30'h0, bus.exception_o}, 32'h2);
    advance();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) drive(1'b1, 32'hC0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h900, 32'h0, 1'b0);
      else drive_quiet(1'b0);
      sample($sformatf("bp.wait%0d", k));
      chk($sformatf("bp.wait%0d.vs", k), {30'h0, bus.redirect_valid_o, bus.stall_o}, 32'h3);
      chk($sformatf("bp.wait%0d.pc", k), bus.redirect_pc_o, 32'h200);
      chk($sformatf("bp.wait%0d.exc", k), {30'h0, bus.exception_o}, 32'h0);
      advance();
    end
    drive_quiet(1'b1);
    sample("bp.accept");
    chk("bp.accept.pc", bus.redirect_pc_o, 32'h200);
    advance();
    drive_quiet(1'b0);
    sample("bp.idle");
    chk("bp.idle.vs", {30'h0, bus.redirect_valid_o, bus.stall_o}, 32'h0);
    advance();

    // mret target is frozen at acceptance even if mepc changes afterwards.
    drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h44, 1'b1);
    sample("mret.N"); advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h999, 1'b1);
    sample("mret.N1");
    chk("mret.N1.restore_flush", {30'h0, bus.mret_restore_o, bus.flush_o}, 32'h3);
    chk("mret.N1.exc_we", {29'h0, bus.exception_o, bus.mepc_we_o}, 32'h0);
    advance();
    sample("mret.N2");
    chk("mret.N2.pc", bus.redirect_pc_o, 32'h44);
    advance();

    // Gating: a flag without instr_valid_i does nothing.
    drive(1'b0, 32'h20, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 1'b1);
    sample("gate.N");
    chk("gate.N.stall", {31'h0, bus.stall_o}, 32'h0);
    advance();
    sample("gate.N1");
    chk("gate.N1.flush_we", {30'h0, bus.flush_o, bus.mepc_we_o}, 32'h0);
    advance();

    // Back-to-back: second trap presented in the IDLE cycle right after the handshake.
    drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h0, 1'b1);
    sample("b2b.a.N"); advance();
    drive_quiet(1'b1);
    sample("b2b.a.N1"); advance();
    sample("b2b.a.N2"); advance();
    drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2004, 32'h0, 1'b1);
    sample("b2b.b.N");
    chk("b2b.b.N.stall", {31'h0, bus.stall_o}, 32'h1);
    advance();
    drive_quiet(1'b1);
    sample("b2b.b.N1");
    chk("b2b.b.N1.exc", {30'h0, bus.exception_o}, 32'h3);
    chk("b2b.b.N1.wdata", bus.mepc_wdata_o, 32'h104);
    advance();
    sample("b2b.b.N2");
    chk("b2b.b.N2.pc", bus.redirect_pc_o, 32'h2004);
    advance();

    // Reset while waiting in REDIRECT drops the redirect.
    drive(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4000, 32'h0, 1'b0);
    sample("rst.N"); advance();
    drive_quiet(1'b0);
    sample("rst.N1"); advance();
    sample("rst.N2");
    chk("rst.N2.valid", {31'h0, bus.redirect_valid_o}, 32'h1);
    rst_i = 1'b0;
    advance();
    advance();
    rst_i = 1'b1;
    sample("rst.after");
    chk("rst.after.valid", {31'h0, bus.redirect_valid_o}, 32'h0);
    chk("rst.after.exc", {30'h0, bus.exception_o}, 32'h0);
    chk("rst.after.pc", bus.redirect_pc_o, 32'h0);
    advance();

    // Random stimulus against the model.
    for (int c = 0; c < 600; c++) begin
      rst_i = ($urandom_range(0, 63) != 0);
      drive($urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom, $urandom, $urandom_range(0, 1) == 1);
      sample($sformatf("rand%0d", c));
      advance();
    end
    rst_i = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
